// File: rtl/alu_cmp_pkg.sv
// Shared definitions for the sequential ALU compare path: state encoding,
// default geometry and the operand/chunk geometry check.
package alu_cmp_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operands must split into a whole number of non-empty chunks.
  function automatic bit width_ok(input int w, input int c);
    return (c > 0) && (w >= c) && ((w % c) == 0);
  endfunction

endpackage

// File: rtl/chunk_compare.sv
// One chunk of the compare: not-equal via XOR/OR-reduce, and a less-than
// that treats the top bit as a sign only on the most significant chunk.
module chunk_compare #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             is_msb,
  output logic             diff,
  output logic             lt
);

  logic w_sign_diff;

  assign diff        = |(a ^ b);
  // Differing signs decide the result outright: the negative operand is smaller.
  assign w_sign_diff = is_msb & (a[CHUNK-1] ^ b[CHUNK-1]);
  // With equal signs, two's complement order matches unsigned order.
  assign lt          = w_sign_diff ? a[CHUNK-1] : (a < b);

endmodule

// File: rtl/seq_compare_unit.sv
// Multi-cycle signed comparator: latches A/B, scans one chunk per cycle from
// the MSB, stops at the first differing chunk and presents isNotEqual /
// isLessThan / scan_count behind a valid/ready handshake.
module seq_compare_unit
  import alu_cmp_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int CHUNK  = DEF_CHUNK,
  localparam int NCHUNK = WIDTH / CHUNK,
  localparam int CNTW   = $clog2(NCHUNK) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             isNotEqual,
  output logic             isLessThan,
  output logic [CNTW-1:0]  scan_count
);

  if (!width_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("seq_compare_unit: WIDTH must be a nonzero multiple of CHUNK");
  end

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b;
  logic [CNTW-1:0]  r_idx;
  logic             w_accept, w_diff, w_lt, w_is_msb, w_last;

  assign w_accept = in_valid & in_ready;
  assign w_is_msb = (r_idx == '0);
  assign w_last   = (r_idx == CNTW'(NCHUNK - 1));

  // Operands are shifted left after each equal chunk, so the chunk under
  // test is always the top CHUNK bits of the latched copies.
  chunk_compare #(.CHUNK(CHUNK)) u_chunk (
    .a      (r_a[WIDTH-1 -: CHUNK]),
    .b      (r_b[WIDTH-1 -: CHUNK]),
    .is_msb (w_is_msb),
    .diff   (w_diff),
    .lt     (w_lt)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and handshake outputs; in_ready stays low while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = ~reset;
        if (w_accept) w_state_nxt = SCAN;
      end
      SCAN: begin
        if (w_diff || w_last) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture, chunk index and result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_a        <= '0;
      r_b        <= '0;
      r_idx      <= '0;
      isNotEqual <= 1'b0;
      isLessThan <= 1'b0;
      scan_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a   <= data_operandA;
            r_b   <= data_operandB;
            r_idx <= '0;
          end
        end
        SCAN: begin
          if (w_diff) begin
            isNotEqual <= 1'b1;
            isLessThan <= w_lt;
            scan_count <= r_idx + 1'b1;
          end else if (w_last) begin
            isNotEqual <= 1'b0;
            isLessThan <= 1'b0;
            scan_count <= CNTW'(NCHUNK);
          end else begin
            r_idx <= r_idx + 1'b1;
            r_a   <= r_a << CHUNK;
            r_b   <= r_b << CHUNK;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_compare_unit.md
Name: seq_compare_unit

Overview:
- Multi-cycle signed magnitude/equality comparator for the ALU compare path.
- Scans operands A and B one CHUNK at a time, from MSB to LSB.
- Each chunk uses an XOR-then-OR-reduce not-equal test. The scan stops at the first differing chunk.
- Produces the ALU flags isNotEqual and isLessThan behind a valid/ready handshake, for branch logic that can tolerate variable latency.

Parameters:
- WIDTH, 32, operand width. Must be a multiple of CHUNK.
- CHUNK, 8, bits examined per scan cycle.
- NCHUNK, WIDTH/CHUNK (derived localparam), number of chunks.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  unit idle and able to accept operands.
- data_operandA  input  WIDTH  operand A, two's complement.
- data_operandB  input  WIDTH  operand B, two's complement.
- out_valid  output  1  flags valid.
- out_ready  input  1  consumer accepts flags.
- isNotEqual  output  1  1 iff A != B.
- isLessThan  output  1  1 iff A < B, signed.
- scan_count  output  $clog2(NCHUNK)+1  number of chunks examined for this result.

Behaviour:
- Reset: one clock (clock), asynchronous active-high reset (reset).
  - While reset is high: state=IDLE; out_valid, isNotEqual, isLessThan and scan_count are 0; in_ready is 0.
  - in_ready returns to 1 in the first cycle after reset deasserts.
- States: IDLE, SCAN, DONE. One transaction in flight; no overlap.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: latch A and B, set idx=0, go to SCAN.
- SCAN:
  - in_ready=0. Each cycle examine chunk idx, i.e. bits [WIDTH-1-idx*CHUNK -: CHUNK].
  - diff = OR-reduce(Achunk ^ Bchunk).
  - If diff=1:
    - isNotEqual=1.
    - For idx=0 with differing sign bits: isLessThan = A[WIDTH-1].
    - Otherwise: isLessThan = (Achunk < Bchunk), unsigned.
    - scan_count=idx+1. Go to DONE.
  - If diff=0 and idx=NCHUNK-1: isNotEqual=0, isLessThan=0, scan_count=NCHUNK, go to DONE.
  - Otherwise idx increments.
- DONE:
  - out_valid=1. Flags and scan_count are held stable until out_ready=1.
  - On out_valid&&out_ready: go to IDLE and clear out_valid. in_ready=1 the following cycle.
  - Flags keep their last values after the handshake; they are only meaningful while out_valid is high.
- Latency: with acceptance at edge E0, out_valid rises at edge E0+k, where k = scan_count (1..NCHUNK). Throughput is at most one result per k+2 cycles.
- in_valid outside IDLE is ignored. Operands may change after acceptance without effect.
- out_ready outside DONE is ignored.
- Reset mid-SCAN or mid-DONE: the transaction is dropped and no out_valid pulse occurs.
- No X-propagation allowed: idx never exceeds NCHUNK-1.

Decomposition:
- Package alu_cmp_pkg holds:
  - state encoding (IDLE=2'd0, SCAN=2'd1, DONE=2'd2);
  - defaults WIDTH=32 and CHUNK=8;
  - an elaboration check that WIDTH%CHUNK==0.
- One combinational sub-module, chunk_compare:
  - inputs: a, b (CHUNK), is_msb;
  - outputs: diff, lt;
  - sign handling applies only when is_msb=1.
- The FSM, index counter and result registers live in the top module.

Test Plan:
- Equal operands: A=0x00000005, B=0x00000005 → isNotEqual=0, isLessThan=0, scan_count=4, out_valid 4 edges after acceptance.
- Sign difference in the first chunk: A=0x80000000, B=0x00000001 → isNotEqual=1, isLessThan=1, scan_count=1. Swapping the operands gives isLessThan=0, scan_count=1.
- Difference only in the last chunk: A=0x00001234, B=0x00001235 → isNotEqual=1, isLessThan=1, scan_count=4. A=0xFFFFFFFF, B=0xFFFFFFFE → isNotEqual=1, isLessThan=0, scan_count=4.
- Backpressure: A=0x01000000, B=0x02000000 with out_ready held low for 3 cycles → out_valid stays 1, flags and scan_count (isLessThan=1, scan_count=1) stay stable, in_ready=0 throughout, and a new in_valid pulse is ignored. Raising out_ready gives in_ready=1 the next cycle.
- Reset mid-scan: accept A=0x00000000, B=0x00000001, pulse reset during cycle 2 of SCAN → outputs go to 0 immediately and no out_valid appears. The next transaction (A=7, B=3) yields isNotEqual=1, isLessThan=0, scan_count=4.
- Back-to-back: an in_valid stream with out_ready tied to 1 → one result per k+2 cycles, and each result matches a reference model over 1000 random signed pairs, including 0x7FFFFFFF and 0x80000000.
